turtle_debug_arbiter: RTL and testbench
=======================================

// Module: turtle_debug_arbiter
// PURPOSE
//  Shares the CPU subsystem's single debug read port (reg/dmem/imem debug addr+rdata, debug_enable)
//  between NUM_REQ requesters (switch/LED io controller, serial monitor, ...). Round-robin arbiter
//  plus a sequencing FSM: issue address, wait fixed read latency, return data to the granted requester.
// PARAMETERS
//  DATA_W      8    register/dmem data width
//  INST_W      16   imem word width; response width
//  D_ADDR_W    12   dmem address width
//  I_ADDR_W    12   imem address width
//  REG_ADDR_W  4    register-file debug address width
//  NUM_REQ     2    number of requesters (>=2)
//  READ_LAT    1    cycles from debug address valid to rdata valid (1..4)
// PORTS
//  clk               in   1                  system clock
//  reset             in   1                  async active-high reset
//  req_valid         in   NUM_REQ            request pending, held until req_ready
//  req_space         in   NUM_REQ*2          per req: 00 REG, 01 DMEM, 10 IMEM, 11 invalid
//  req_addr          in   NUM_REQ*12         per req address (ADDR_W=max(D_ADDR_W,I_ADDR_W))
//  req_ready         out  NUM_REQ            one-hot accept pulse
//  rsp_valid         out  NUM_REQ            one-hot 1-cycle response pulse
//  rsp_data          out  INST_W             response data, shared, valid with rsp_valid
//  rsp_err           out  1                  invalid space, valid with rsp_valid
//  debug_enable      out  1                  freezes CPU while a debug access is in flight
//  reg_debug_addr    out  REG_ADDR_W         to subsystem
//  dmem_debug_addr   out  D_ADDR_W           to subsystem
//  imem_debug_addr   out  I_ADDR_W           to subsystem
//  reg_debug_rdata   in   DATA_W             from subsystem
//  dmem_debug_rdata  in   DATA_W             from subsystem
//  imem_debug_rdata  in   INST_W             from subsystem
// BEHAVIOUR
//  Reset: state IDLE, rr pointer=0, all outputs 0 (addr buses 0, rsp_data 0, debug_enable 0).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one transaction in flight, no pipelining.
//  IDLE: if any req_valid, grant first valid at/after rr pointer; req_ready[g]=1 that cycle (t);
//   latch space/addr/g; rr pointer <= g+1 mod NUM_REQ. No valid: stay, req_ready=0.
//  ISSUE (t+1): drive latched addr on selected *_debug_addr (truncate to port width, others hold
//   previous value); debug_enable=1; latency counter loaded READ_LAT-1.
//  WAIT: debug_enable=1, addr held; decrement counter; at 0 sample rdata of selected space
//   (DATA_W zero-extended to INST_W) into rsp_data. Sample cycle = t+1+READ_LAT.
//  RESP (t+2+READ_LAT): rsp_valid[g]=1 for exactly one cycle; debug_enable drops to 0; -> IDLE.
//   Earliest next req_ready: t+3+READ_LAT (IDLE). rsp_data holds until next sample.
//  Invalid space 11: no debug_enable, no addr change; ISSUE->RESP directly, rsp_data=0, rsp_err=1,
//   response at t+2. rsp_err=0 on valid responses.
//  Fairness: requester just served has lowest priority next; with all valid, strict rotation.
//  req_valid deassert before ready: allowed, simply not granted. Changes of a non-granted req ignored.
//  Request changes after accept ignored (latched copy used).
//  Reset mid-transaction: immediate return to IDLE, pending response dropped (no rsp_valid),
//   debug_enable 0 asynchronously.
// STRUCTURE
//  Package turtle_debug_pkg: dbg_space_e {DBG_REG, DBG_DMEM, DBG_IMEM, DBG_INVALID},
//   arb_state_e {IDLE, ISSUE, WAIT, RESP}, ADDR_W helper function.
//  Sub-module: turtle_rr_arbiter (NUM_REQ, valid vector + pointer -> one-hot grant + index).
//  FSM, latches, latency counter and mux in this module.
// TESTING
//  Req0 REG addr 3, reg rdata=0xA5, READ_LAT=1 -> ready@t, reg_debug_addr=3 @t+1, rsp_valid[0]@t+3, data 0x00A5.
//  Req0,req1 valid together from reset, held -> grant order 0,1,0,1; no requester served twice in a row.
//  Req1 IMEM 0xFFF, rdata 0xBEEF -> imem_debug_addr=0xFFF, rsp_data 0xBEEF, debug_enable high 1+READ_LAT cycles.
//  Req0 space 11 -> rsp_valid[0]@t+2, rsp_err=1, rsp_data 0, debug_enable never asserted.
//  READ_LAT=3, DMEM 0x800, reset asserted in WAIT -> no rsp_valid, outputs 0, next req served normally.
//  Req0 valid 1 cycle while busy then dropped -> never granted, no response.

Source files
------------

// File: rtl/turtle_debug_pkg.sv
// Shared types for the debug-port arbiter: address spaces,
// sequencer states and the request address width helper.
package turtle_debug_pkg;

  typedef enum logic [1:0] {
    DBG_REG     = 2'b00,
    DBG_DMEM    = 2'b01,
    DBG_IMEM    = 2'b10,
    DBG_INVALID = 2'b11
  } dbg_space_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  function automatic int addr_w(input int d_w, input int i_w);
    return (d_w > i_w) ? d_w : i_w;
  endfunction

endpackage

// File: rtl/turtle_rr_arbiter.sv
// Round-robin pick: first valid requester at or after the
// pointer, returned as one-hot grant plus index.
module turtle_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       found
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        idx      = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turtle_debug_arbiter.sv
// Shares the CPU debug read port between requesters:
// round-robin grant, issue address, wait latency, return data.
module turtle_debug_arbiter
  import turtle_debug_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int INST_W     = 16,
  parameter int D_ADDR_W   = 12,
  parameter int I_ADDR_W   = 12,
  parameter int REG_ADDR_W = 4,
  parameter int NUM_REQ    = 2,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*2-1:0]  req_space,
  input  logic [NUM_REQ*addr_w(D_ADDR_W, I_ADDR_W)-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [INST_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic                  debug_enable,
  output logic [REG_ADDR_W-1:0] reg_debug_addr,
  output logic [D_ADDR_W-1:0]   dmem_debug_addr,
  output logic [I_ADDR_W-1:0]   imem_debug_addr,
  input  logic [DATA_W-1:0]     reg_debug_rdata,
  input  logic [DATA_W-1:0]     dmem_debug_rdata,
  input  logic [INST_W-1:0]     imem_debug_rdata
);

  localparam int ADDR_W = addr_w(D_ADDR_W, I_ADDR_W);
  localparam int IDX_W  = $clog2(NUM_REQ);

  arb_state_e       state, state_nxt;
  dbg_space_e       sel_space, req_sp;
  logic [IDX_W-1:0] rr_ptr, sel_idx, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic             gnt_any;
  logic [ADDR_W-1:0] req_ad;
  logic [2:0]       cnt;

  turtle_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(gnt),
    .idx  (gnt_idx),
    .found(gnt_any)
  );

  assign req_sp = dbg_space_e'(req_space[int'(gnt_idx)*2 +: 2]);
  assign req_ad = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << sel_idx) : '0;
  assign debug_enable = (state == WAIT) ||
                        (state == ISSUE && sel_space != DBG_INVALID);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (gnt_any) state_nxt = ISSUE;
      ISSUE: state_nxt = (sel_space == DBG_INVALID) ? RESP : WAIT;
      WAIT:  if (cnt == '0) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      sel_space       <= DBG_REG;
      sel_idx         <= '0;
      rr_ptr          <= '0;
      cnt             <= '0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      reg_debug_addr  <= '0;
      dmem_debug_addr <= '0;
      imem_debug_addr <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (gnt_any) begin
          sel_idx   <= gnt_idx;
          sel_space <= req_sp;
          rr_ptr    <= (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
          // address goes out on the edge into ISSUE, so it is valid there
          unique case (req_sp)
            DBG_REG:     reg_debug_addr  <= req_ad[REG_ADDR_W-1:0];
            DBG_DMEM:    dmem_debug_addr <= req_ad[D_ADDR_W-1:0];
            DBG_IMEM:    imem_debug_addr <= req_ad[I_ADDR_W-1:0];
            DBG_INVALID: ;
          endcase
        end
        ISSUE: begin
          cnt <= 3'(READ_LAT - 1);
          if (sel_space == DBG_INVALID) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_err <= 1'b0;
            unique case (sel_space)
              DBG_REG:     rsp_data <= INST_W'(reg_debug_rdata);
              DBG_DMEM:    rsp_data <= INST_W'(dmem_debug_rdata);
              DBG_IMEM:    rsp_data <= imem_debug_rdata;
              DBG_INVALID: rsp_data <= '0;
            endcase
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turtle_debug_arbiter.sv
// Bench: two arbiters (read latency 1 and 3) against a
// timeline model plus directed literal checks.
module tb_turtle_debug_arbiter;

  localparam int N  = 2;
  localparam int AW = 12;

  int lat [2] = '{1, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [N-1:0]    rv   [2];
  logic [2*N-1:0]  rs   [2];
  logic [N*AW-1:0] ra   [2];
  logic [N-1:0]    rdy  [2];
  logic [N-1:0]    rspv [2];
  logic [15:0]     rdat [2];
  logic            rerr [2];
  logic            den  [2];
  logic [3:0]      raddr[2];
  logic [11:0]     daddr[2];
  logic [11:0]     iaddr[2];
  logic [7:0]      rrd  [2];
  logic [7:0]      drd  [2];
  logic [15:0]     ird  [2];

  bit [7:0]  reg_mem [16];
  bit [7:0]  dmem    [4096];
  bit [15:0] imem    [4096];
  bit [3:0]  rh [2][4];
  bit [11:0] dh [2][4];
  bit [11:0] ih [2][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  turtle_debug_arbiter #(.READ_LAT(1)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_space(rs[0]), .req_addr(ra[0]),
    .req_ready(rdy[0]), .rsp_valid(rspv[0]), .rsp_data(rdat[0]),
    .rsp_err(rerr[0]), .debug_enable(den[0]),
    .reg_debug_addr(raddr[0]), .dmem_debug_addr(daddr[0]),
    .imem_debug_addr(iaddr[0]),
    .reg_debug_rdata(rrd[0]), .dmem_debug_rdata(drd[0]),
    .imem_debug_rdata(ird[0])
  );

  turtle_debug_arbiter #(.READ_LAT(3)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_space(rs[1]), .req_addr(ra[1]),
    .req_ready(rdy[1]), .rsp_valid(rspv[1]), .rsp_data(rdat[1]),
    .rsp_err(rerr[1]), .debug_enable(den[1]),
    .reg_debug_addr(raddr[1]), .dmem_debug_addr(daddr[1]),
    .imem_debug_addr(iaddr[1]),
    .reg_debug_rdata(rrd[1]), .dmem_debug_rdata(drd[1]),
    .imem_debug_rdata(ird[1])
  );

  // subsystem: rdata reflects the address seen READ_LAT cycles ago
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 3; j > 0; j--) begin
        rh[k][j] <= rh[k][j-1];
        dh[k][j] <= dh[k][j-1];
        ih[k][j] <= ih[k][j-1];
      end
      rh[k][0] <= raddr[k];
      dh[k][0] <= daddr[k];
      ih[k][0] <= iaddr[k];
    end
  end

  assign rrd[0] = reg_mem[rh[0][0]];
  assign drd[0] = dmem[dh[0][0]];
  assign ird[0] = imem[ih[0][0]];
  assign rrd[1] = reg_mem[rh[1][2]];
  assign drd[1] = dmem[dh[1][2]];
  assign ird[1] = imem[ih[1][2]];

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h",
               name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_data(input logic [1:0] sp,
                                           input logic [11:0] ad);
    case (sp)
      2'd0:    return {8'h00, reg_mem[ad[3:0]]};
      2'd1:    return {8'h00, dmem[ad]};
      2'd2:    return imem[ad];
      default: return 16'h0000;
    endcase
  endfunction

  // timeline model: one transaction occupies fixed cycle slots
  int         free_at [2];
  int         ptr     [2];
  int         p_t     [2];
  int         p_g     [2];
  bit         pend    [2];
  logic [1:0] p_sp    [2];
  logic [11:0] p_ad   [2];
  logic [3:0] e_ra    [2];
  logic [11:0] e_da   [2];
  logic [11:0] e_ia   [2];
  logic [15:0] e_dat  [2];
  logic [N-1:0] last_rdy [2];
  logic [N-1:0] e_rdy, e_rv;
  logic e_en;
  int   g;

  initial begin
    for (int k = 0; k < 2; k++) begin
      free_at[k] = 0; ptr[k] = 0; pend[k] = 0;
      e_ra[k] = '0; e_da[k] = '0; e_ia[k] = '0; e_dat[k] = '0;
      last_rdy[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_rdy = '0;
      e_rv  = '0;
      e_en  = 1'b0;
      if (reset) begin
        free_at[k] = 0; ptr[k] = 0; pend[k] = 0;
        e_ra[k] = '0; e_da[k] = '0; e_ia[k] = '0; e_dat[k] = '0;
      end else begin
        if (pend[k]) begin
          if (p_sp[k] != 2'd3) begin
            if (cyc == p_t[k] + 1) begin
              case (p_sp[k])
                2'd0:    e_ra[k] = p_ad[k][3:0];
                2'd1:    e_da[k] = p_ad[k];
                default: e_ia[k] = p_ad[k];
              endcase
            end
            e_en = (cyc >= p_t[k] + 1) && (cyc <= p_t[k] + 1 + lat[k]);
            if (cyc == p_t[k] + 2 + lat[k]) begin
              e_rv = N'(1) << p_g[k];
              e_dat[k] = mem_data(p_sp[k], p_ad[k]);
            end
          end else if (cyc == p_t[k] + 2) begin
            e_rv = N'(1) << p_g[k];
            e_dat[k] = 16'h0000;
          end
        end
        if (cyc >= free_at[k]) begin
          g = -1;
          for (int i = 0; i < N; i++)
            if (g < 0 && rv[k][(ptr[k] + i) % N]) g = (ptr[k] + i) % N;
          if (g >= 0) begin
            e_rdy = N'(1) << g;
            pend[k] = 1'b1;
            p_t[k] = cyc;
            p_g[k] = g;
            p_sp[k] = rs[k][2*g +: 2];
            p_ad[k] = ra[k][AW*g +: AW];
            free_at[k] = cyc + ((p_sp[k] == 2'd3) ? 3 : 3 + lat[k]);
            ptr[k] = (g + 1) % N;
          end
        end
      end
      chk("req_ready", k, rdy[k], e_rdy);
      chk("rsp_valid", k, rspv[k], e_rv);
      chk("debug_enable", k, den[k], e_en);
      chk("reg_debug_addr", k, raddr[k], e_ra[k]);
      chk("dmem_debug_addr", k, daddr[k], e_da[k]);
      chk("imem_debug_addr", k, iaddr[k], e_ia[k]);
      chk("rsp_data", k, rdat[k], e_dat[k]);
      if (e_rv != '0) chk("rsp_err", k, rerr[k], p_sp[k] == 2'd3);
      last_rdy[k] = rdy[k];
    end
  end

  task automatic at_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic req_one(input int k, input int r, input logic [1:0] sp,
                         input logic [11:0] ad, output int t,
                         output int wait_c);
    int n, c0;
    t = -1;
    @(posedge clk); #1;
    c0 = cyc;
    rv[k][r] = 1'b1;
    rs[k][2*r +: 2] = sp;
    ra[k][AW*r +: AW] = ad;
    n = 0;
    while (t < 0 && n < 40) begin
      @(negedge clk);
      if (rdy[k][r]) t = cyc;
      n++;
    end
    wait_c = t - c0;
    if (t < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout dut%0d req%0d got=none want=ready", k, r);
      t = cyc;
    end
    @(posedge clk); #1;
    rv[k][r] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  int t, w, n, cnt_a, cnt_b;
  int order[$];
  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = '0; rs[k] = '0; ra[k] = '0;
    end
    for (int i = 0; i < 16; i++) reg_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = 8'($urandom);
      imem[i] = 16'($urandom);
    end
    reg_mem[3] = 8'hA5;
    imem[12'hFFF] = 16'hBEEF;
    dmem[12'h800] = 8'h3C;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // both requesters held from reset: strict rotation
    @(posedge clk); #1;
    rv[0] = 2'b11; rs[0] = '0; ra[0] = {12'h00A, 12'h005};
    n = 0;
    while (order.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (rdy[0] != '0) order.push_back(rdy[0][1] ? 1 : 0);
    end
    @(posedge clk); #1;
    rv[0] = '0;
    if (order.size() < 4) begin
      n_tests++; n_fail++;
      $display("FAIL grant_order got=%0d grants want=4", order.size());
    end
    foreach (order[i]) chk("grant_order", 0, order[i], exp_order[i]);
    idle(8);

    // REG addr 3 on the latency-1 port
    req_one(0, 0, 2'd0, 12'h003, t, w);
    chk("lit_ready_lat", 0, w, 0);
    at_cyc(t + 1);
    chk("lit_reg_addr", 0, raddr[0], 4'h3);
    at_cyc(t + 3);
    chk("lit_rsp_valid", 0, rspv[0], 2'b01);
    chk("lit_rsp_data", 0, rdat[0], 16'h00A5);
    chk("lit_rsp_err", 0, rerr[0], 1'b0);
    idle(6);

    // IMEM top address from requester 1
    req_one(0, 1, 2'd2, 12'hFFF, t, w);
    cnt_a = 0;
    for (int c = 1; c <= 4; c++) begin
      at_cyc(t + c);
      cnt_a += int'(den[0]);
      if (c == 1) chk("lit_imem_addr", 0, iaddr[0], 12'hFFF);
      if (c == 3) begin
        chk("lit_imem_rsp", 0, rspv[0], 2'b10);
        chk("lit_imem_data", 0, rdat[0], 16'hBEEF);
      end
    end
    chk("lit_den_cycles", 0, cnt_a, 2);
    idle(6);

    // invalid space
    req_one(0, 0, 2'd3, 12'h123, t, w);
    cnt_a = 0;
    for (int c = 1; c <= 3; c++) begin
      at_cyc(t + c);
      cnt_a += int'(den[0]);
      if (c == 2) begin
        chk("lit_inv_rsp", 0, rspv[0], 2'b01);
        chk("lit_inv_err", 0, rerr[0], 1'b1);
        chk("lit_inv_data", 0, rdat[0], 16'h0000);
        chk("lit_inv_addr", 0, iaddr[0], 12'hFFF);
      end
    end
    chk("lit_inv_den", 0, cnt_a, 0);
    idle(6);

    // short-lived request while busy is never served
    req_one(0, 1, 2'd0, 12'h005, t, w);
    rv[0][0] = 1'b1; rs[0][1:0] = 2'd1; ra[0][11:0] = 12'h010;
    @(posedge clk); #1;
    rv[0][0] = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int c = 2; c <= 8; c++) begin
      at_cyc(t + c);
      cnt_a += int'(rdy[0][0]);
      cnt_b += int'(rspv[0][0]);
    end
    chk("lit_drop_ready", 0, cnt_a, 0);
    chk("lit_drop_rsp", 0, cnt_b, 0);
    idle(6);

    // reset while waiting on the latency-3 port
    req_one(1, 0, 2'd1, 12'h800, t, w);
    at_cyc(t + 2);
    @(posedge clk); #1;
    reset = 1'b1;
    at_cyc(t + 3);
    chk("lit_rst_den", 1, den[1], 1'b0);
    chk("lit_rst_addr", 1, daddr[1], 12'h000);
    chk("lit_rst_data", 1, rdat[1], 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_b = 0;
    for (int c = 5; c <= 8; c++) begin
      at_cyc(t + c);
      cnt_b += int'(rspv[1] != '0);
    end
    chk("lit_rst_norsp", 1, cnt_b, 0);
    req_one(1, 0, 2'd1, 12'h800, t, w);
    chk("lit_post_rst_lat", 1, w, 0);
    at_cyc(t + 1);
    chk("lit_post_rst_addr", 1, daddr[1], 12'h800);
    at_cyc(t + 5);
    chk("lit_post_rst_rsp", 1, rspv[1], 2'b01);
    chk("lit_post_rst_data", 1, rdat[1], 16'h003C);
    idle(8);

    // random traffic on both ports
    for (int it = 0; it < 4000; it++) begin
      @(posedge clk); #1;
      if (it == 2000) begin
        for (int k = 0; k < 2; k++) rv[k] = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          for (int r = 0; r < N; r++) begin
            if (rv[k][r] && !last_rdy[k][r]) begin
              if ($urandom_range(31) == 0) rv[k][r] = 1'b0;
            end else if ((rv[k][r] && $urandom_range(1) == 1) ||
                         (!rv[k][r] && $urandom_range(7) < 3)) begin
              rv[k][r] = 1'b1;
              rs[k][2*r +: 2] = 2'($urandom);
              ra[k][AW*r +: AW] = ($urandom_range(7) == 0) ?
                                  12'hFFF : 12'($urandom);
            end else begin
              rv[k][r] = 1'b0;
            end
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) rv[k] = '0;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
